// File: rtl/pacman_mover.sv
// pacman_mover
//   Produces the Pacman centre position for the frame renderer. Button
//   presses are latched as a persistent request. On every STEP_DIV-th tick
//   the mover tries the request first and then the current heading, using
//   the wall flags for the current position. X wraps through the tunnel
//   when it is enabled. Monster contact holds the sprite frozen for
//   DEAD_TICKS ticks, after which it respawns at the start position.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low reset
//   tick           1 ms enable pulse, one clk wide
//   btn[3:0]       [0]=L [1]=U [2]=R [3]=D, level, active-high
//   wall_l/u/r/d   1 = wall 12 px away in that direction
//   caught         monster overlap, level
//   p_x, p_y       Pacman centre in map pixels
//   dir            heading, 0=L 1=U 2=R 3=D
//   moving         1 while in MOVING
//   dead           1 while in DEAD
module pacman_mover #(
   parameter int START_X    = 174,
   parameter int START_Y    = 300,
   parameter int MAP_W      = 347,
   parameter int MAP_H      = 405,
   parameter int HALF       = 12,
   parameter int STEP_DIV   = 8,
   parameter int DEAD_TICKS = 500,
   parameter int TUNNEL_EN  = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic [3:0] btn,
   input  logic       wall_l,
   input  logic       wall_u,
   input  logic       wall_r,
   input  logic       wall_d,
   input  logic       caught,
   output logic [8:0] p_x,
   output logic [8:0] p_y,
   output logic [1:0] dir,
   output logic       moving,
   output logic       dead
);

   localparam int DCW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;

   localparam logic [8:0]     X_MIN     = 9'(HALF);
   localparam logic [8:0]     X_MAX     = 9'(MAP_W - HALF - 1);
   localparam logic [8:0]     Y_MIN     = 9'(HALF);
   localparam logic [8:0]     Y_MAX     = 9'(MAP_H - HALF - 1);
   localparam logic [7:0]     STEP_LAST = 8'(STEP_DIV - 1);
   localparam logic [DCW-1:0] DEAD_LAST = DCW'(DEAD_TICKS - 1);

   localparam logic [1:0] D_L = 2'd0;
   localparam logic [1:0] D_U = 2'd1;
   localparam logic [1:0] D_R = 2'd2;
   localparam logic [1:0] D_D = 2'd3;

   typedef enum logic [1:0] {
      ST_STOPPED = 2'd0,
      ST_MOVING  = 2'd1,
      ST_DEAD    = 2'd2
   } state_t;

   state_t         state, state_nxt;
   logic [8:0]     x_nxt, y_nxt;
   logic [1:0]     dir_nxt;
   logic [1:0]     req, req_nxt;
   logic           req_valid, rv_nxt;
   logic [7:0]     step_cnt, sc_nxt;
   logic [DCW-1:0] dead_cnt, dc_nxt;

   logic [3:0]     walls;
   logic           step_evt;
   logic           mv_en;
   logic [1:0]     mv_dir;

   // Up beats down beats left beats right when several buttons are held.
   function automatic logic [1:0] btn_priority(input logic [3:0] b);
      if (b[1])      return D_U;
      else if (b[3]) return D_D;
      else if (b[0]) return D_L;
      else           return D_R;
   endfunction

   assign walls    = {wall_d, wall_r, wall_u, wall_l};
   assign step_evt = tick && (step_cnt == STEP_LAST);
   assign moving   = (state == ST_MOVING);
   assign dead     = (state == ST_DEAD);

   always_comb begin
      state_nxt = state;
      x_nxt     = p_x;
      y_nxt     = p_y;
      dir_nxt   = dir;
      req_nxt   = req;
      rv_nxt    = req_valid;
      sc_nxt    = step_cnt;
      dc_nxt    = dead_cnt;
      mv_en     = 1'b0;
      mv_dir    = dir;

      if (state == ST_DEAD) begin
         // Buttons are ignored and the step divider is parked while dead.
         sc_nxt = '0;
         if (tick) begin
            if (dead_cnt == DEAD_LAST) begin
               state_nxt = ST_STOPPED;
               x_nxt     = 9'(START_X);
               y_nxt     = 9'(START_Y);
               dir_nxt   = D_L;
               rv_nxt    = 1'b0;
               dc_nxt    = '0;
            end else begin
               dc_nxt = dead_cnt + DCW'(1);
            end
         end
      end else begin
         if (tick)
            sc_nxt = step_evt ? 8'd0 : step_cnt + 8'd1;

         if (btn != 4'd0) begin
            req_nxt = btn_priority(btn);
            rv_nxt  = 1'b1;
         end

         if (caught) begin
            // Contact wins over a coincident step: the position freezes.
            state_nxt = ST_DEAD;
            dc_nxt    = '0;
            sc_nxt    = '0;
         end else if (step_evt) begin
            // The buffered request is tried first; otherwise keep heading.
            if (req_valid && !walls[req]) begin
               dir_nxt = req;
               mv_dir  = req;
               mv_en   = 1'b1;
            end else if (state == ST_MOVING && !walls[dir]) begin
               mv_dir = dir;
               mv_en  = 1'b1;
            end

            state_nxt = mv_en ? ST_MOVING : ST_STOPPED;
            if (mv_en) begin
               case (mv_dir)
                  D_L: begin
                     if (p_x != X_MIN)          x_nxt = p_x - 9'd1;
                     else if (TUNNEL_EN != 0)   x_nxt = X_MAX;
                     else                       state_nxt = ST_STOPPED;
                  end
                  D_R: begin
                     if (p_x != X_MAX)          x_nxt = p_x + 9'd1;
                     else if (TUNNEL_EN != 0)   x_nxt = X_MIN;
                     else                       state_nxt = ST_STOPPED;
                  end
                  D_U: begin
                     if (p_y != Y_MIN)          y_nxt = p_y - 9'd1;
                     else                       state_nxt = ST_STOPPED;
                  end
                  default: begin
                     if (p_y != Y_MAX)          y_nxt = p_y + 9'd1;
                     else                       state_nxt = ST_STOPPED;
                  end
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_STOPPED;
         p_x       <= 9'(START_X);
         p_y       <= 9'(START_Y);
         dir       <= D_L;
         req       <= D_L;
         req_valid <= 1'b0;
         step_cnt  <= '0;
         dead_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         p_x       <= x_nxt;
         p_y       <= y_nxt;
         dir       <= dir_nxt;
         req       <= req_nxt;
         req_valid <= rv_nxt;
         step_cnt  <= sc_nxt;
         dead_cnt  <= dc_nxt;
      end
   end

endmodule

// File: tb/tb_pacman_mover.sv
module tb_pacman_mover;

   localparam int START_X    = 174;
   localparam int START_Y    = 300;
   localparam int MAP_W      = 347;
   localparam int MAP_H      = 405;
   localparam int HALF       = 12;
   localparam int STEP_DIV   = 8;
   localparam int DEAD_TICKS = 500;
   localparam int XMAX       = MAP_W - HALF - 1;
   localparam int YMAX       = MAP_H - HALF - 1;

   localparam int S_STOP = 0;
   localparam int S_MOVE = 1;
   localparam int S_DEAD = 2;

   logic       clk;
   logic       reset;
   logic       tick;
   logic [3:0] btn;
   logic       wall_l, wall_u, wall_r, wall_d;
   logic       caught;

   logic [8:0] px  [2];
   logic [8:0] py  [2];
   logic [1:0] dr  [2];
   logic       mv  [2];
   logic       dd  [2];

   // Instance 0 has the tunnel, instance 1 does not; both see the same inputs.
   pacman_mover #(.TUNNEL_EN(1)) u_dut_tun (
      .clk(clk), .reset(reset), .tick(tick), .btn(btn),
      .wall_l(wall_l), .wall_u(wall_u), .wall_r(wall_r), .wall_d(wall_d),
      .caught(caught), .p_x(px[0]), .p_y(py[0]), .dir(dr[0]),
      .moving(mv[0]), .dead(dd[0]));

   pacman_mover #(.TUNNEL_EN(0)) u_dut_notun (
      .clk(clk), .reset(reset), .tick(tick), .btn(btn),
      .wall_l(wall_l), .wall_u(wall_u), .wall_r(wall_r), .wall_d(wall_d),
      .caught(caught), .p_x(px[1]), .p_y(py[1]), .dir(dr[1]),
      .moving(mv[1]), .dead(dd[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;
   bit cmp_en = 1'b0;

   // Reference model: position, heading, mode, latched request, dividers.
   int m_x [2], m_y [2], m_dir [2], m_st [2];
   int m_req [2], m_rv [2], m_sc [2], m_dc [2];

   int DX [4]   = '{-1, 0, 1, 0};
   int DY [4]   = '{0, -1, 0, 1};
   int PRIO [4] = '{1, 3, 0, 2};

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
   endtask

   task automatic model_reset(input int k);
      m_x[k] = START_X; m_y[k] = START_Y; m_dir[k] = 0; m_st[k] = S_STOP;
      m_req[k] = 0; m_rv[k] = 0; m_sc[k] = 0; m_dc[k] = 0;
   endtask

   task automatic model_step(input int k);
      int  w [4];
      int  pick, nx, ny;
      bit  step;
      w[0] = int'(wall_l); w[1] = int'(wall_u); w[2] = int'(wall_r); w[3] = int'(wall_d);
      if (m_st[k] == S_DEAD) begin
         m_sc[k] = 0;
         if (tick) begin
            if (m_dc[k] == DEAD_TICKS - 1) begin
               m_x[k] = START_X; m_y[k] = START_Y; m_dir[k] = 0;
               m_rv[k] = 0; m_st[k] = S_STOP; m_dc[k] = 0;
            end else begin
               m_dc[k]++;
            end
         end
         return;
      end
      step = tick && (m_sc[k] == STEP_DIV - 1);
      if (tick) m_sc[k] = (m_sc[k] + 1) % STEP_DIV;
      if (caught) begin
         m_st[k] = S_DEAD; m_dc[k] = 0; m_sc[k] = 0;
      end else if (step) begin
         pick = -1;
         if (m_rv[k] != 0 && w[m_req[k]] == 0) begin
            pick = m_req[k];
            m_dir[k] = pick;
         end else if (m_st[k] == S_MOVE && w[m_dir[k]] == 0) begin
            pick = m_dir[k];
         end
         m_st[k] = S_STOP;
         if (pick >= 0) begin
            nx = m_x[k] + DX[pick];
            ny = m_y[k] + DY[pick];
            if (k == 0) begin
               if (nx < HALF) nx = XMAX;
               else if (nx > XMAX) nx = HALF;
            end
            if (nx >= HALF && nx <= XMAX && ny >= HALF && ny <= YMAX) begin
               m_x[k] = nx; m_y[k] = ny; m_st[k] = S_MOVE;
            end
         end
      end
      if (btn != 4'd0) begin
         for (int i = 3; i >= 0; i--)
            if (btn[PRIO[i]]) m_req[k] = PRIO[i];
         m_rv[k] = 1;
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_step(0);
         model_step(1);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("p_x[%0d]", k), int'(px[k]), m_x[k]);
            chk($sformatf("p_y[%0d]", k), int'(py[k]), m_y[k]);
            chk($sformatf("dir[%0d]", k), int'(dr[k]), m_dir[k]);
            chk($sformatf("moving[%0d]", k), int'(mv[k]), (m_st[k] == S_MOVE) ? 1 : 0);
            chk($sformatf("dead[%0d]", k), int'(dd[k]), (m_st[k] == S_DEAD) ? 1 : 0);
         end
      end
   end

   task automatic clks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         @(posedge clk);
         #1;
         tick = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic [3:0] b);
      btn = b;
      @(posedge clk);
      #1;
      btn = 4'd0;
   endtask

   task automatic pin(input string name, input int k, input int x, input int y,
                      input int d, input int m, input int de);
      chk({name, "/x"}, int'(px[k]), x);
      chk({name, "/y"}, int'(py[k]), y);
      chk({name, "/dir"}, int'(dr[k]), d);
      chk({name, "/moving"}, int'(mv[k]), m);
      chk({name, "/dead"}, int'(dd[k]), de);
   endtask

   initial begin
      reset = 1'b0; tick = 1'b0; btn = 4'd0; caught = 1'b0;
      wall_l = 1'b0; wall_u = 1'b0; wall_r = 1'b0; wall_d = 1'b0;
      model_reset(0);
      model_reset(1);
      clks(3);
      pin("reset0", 0, 174, 300, 0, 0, 0);
      pin("reset1", 1, 174, 300, 0, 0, 0);
      reset = 1'b1;
      cmp_en = 1'b1;
      clks(2);

      // Start moving left from rest.
      press(4'b0001);
      ticks(7);
      chk("start/moving_before_8th", int'(mv[0]), 0);
      ticks(1);
      pin("start8", 0, 173, 300, 0, 1, 0);
      ticks(8);
      pin("start16", 0, 172, 300, 0, 1, 0);

      // Buffered turn up while heading right.
      press(4'b0100);
      ticks(8);
      pin("go_right", 0, 173, 300, 2, 1, 0);
      wall_u = 1'b1;
      press(4'b0010);
      ticks(8);
      pin("up_blocked", 0, 174, 300, 2, 1, 0);
      wall_u = 1'b0;
      ticks(8);
      pin("turn_up", 0, 174, 299, 1, 1, 0);

      // Stop at a wall while a blocked up request is pending.
      wall_u = 1'b1;
      press(4'b0001);
      ticks(8);
      pin("go_left", 0, 173, 299, 0, 1, 0);
      press(4'b0010);
      wall_l = 1'b1;
      ticks(8);
      pin("wall_stop", 0, 173, 299, 0, 0, 0);
      wall_l = 1'b0;
      ticks(8);
      pin("stay_stopped", 0, 173, 299, 0, 0, 0);

      // Run left to the X limit, then through the tunnel.
      press(4'b0001);
      ticks(161 * STEP_DIV);
      pin("at_left0", 0, 12, 299, 0, 1, 0);
      pin("at_left1", 1, 12, 299, 0, 1, 0);
      ticks(8);
      pin("tunnel", 0, 334, 299, 0, 1, 0);
      pin("no_tunnel", 1, 12, 299, 0, 0, 0);

      // Death on the same edge as a step event, buttons held while dead.
      ticks(7);
      tick = 1'b1;
      caught = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      caught = 1'b0;
      pin("caught0", 0, 334, 299, 0, 0, 1);
      pin("caught1", 1, 12, 299, 0, 0, 1);
      btn = 4'b0100;
      ticks(DEAD_TICKS - 1);
      chk("still_dead", int'(dd[0]), 1);
      btn = 4'd0;
      ticks(1);
      pin("respawn0", 0, 174, 300, 0, 0, 0);
      pin("respawn1", 1, 174, 300, 0, 0, 0);
      ticks(8);
      pin("after_respawn", 0, 174, 300, 0, 0, 0);

      // Asynchronous reset in the middle of DEAD.
      press(4'b0100);
      ticks(8);
      pin("pre_death", 0, 175, 300, 2, 1, 0);
      caught = 1'b1;
      clks(1);
      caught = 1'b0;
      ticks(3);
      chk("dead_before_reset", int'(dd[0]), 1);
      #2;
      reset = 1'b0;
      #1;
      pin("async_reset", 0, 174, 300, 0, 0, 0);
      clks(2);
      reset = 1'b1;
      clks(2);

      // Randomised traffic checked against the model every cycle.
      for (int c = 0; c < 20000; c++) begin
         tick = ($urandom_range(0, 1) == 1);
         btn = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
         if ($urandom_range(0, 15) == 0)
            {wall_d, wall_r, wall_u, wall_l} = 4'($urandom_range(0, 15));
         caught = ($urandom_range(0, 599) == 0);
         @(posedge clk);
         #1;
      end
      tick = 1'b0; btn = 4'd0; caught = 1'b0;
      clks(2);
      cmp_en = 1'b0;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
